serial_match_scheduler: RTL
===========================

# serial_match_scheduler

Shares one bit-serial "two consecutive 1s" Mealy detector among four requesters. Each requester presents an 8-bit word. A round-robin arbiter grants one requester at a time. The block shifts the granted word MSB-first through the detector, counts detector hits, and returns the count with a one-cycle done pulse tagged with the requester ID. It sits between the requester front-ends and the shared serial detection resource.

## Interface
- W, 8, word width in bits; a power of two, at least 2.
- N, 4, number of requesters; fixed at 4, with the ID 2 bits wide.
- Clock  input  1  single clock, rising-edge.
- Resetn  input  1  asynchronous, active-low reset.
- req  input  4  request per requester; bit i belongs to requester i.
- din  input  4*W  requester words; din[i*W +: W] is requester i's word.
- gnt  output  4  one-hot grant, registered.
- busy  output  1  high in the SHIFT and DONE states.
- sbit  output  1  bit currently presented to the detector; 0 when not in SHIFT.
- z  output  1  Mealy detector output, combinational from sbit and the detector state; 0 when not in SHIFT.
- done  output  1  one-cycle pulse; count and done_id are valid in that cycle.
- done_id  output  2  ID of the requester whose job just completed; held until the next done.
- count  output  $clog2(W)+1  number of z hits in the completed word; held until the next done.

## Operation
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is high, pick the winner by round-robin from pointer ptr. Priority order is ptr, ptr+1, … mod 4.
  - On that edge: load shreg with the winner's din slice, set gnt to the winner's one-hot code, clear the bit counter, the hit counter and detector state y, then enter SHIFT.
  - If no req bit is high, stay in IDLE.
- SHIFT:
  - sbit = shreg[W-1].
  - Detector: state y is the previous bit. z = sbit & y. Next y = sbit.
  - Each edge: shift shreg left by one, add z to the hit counter, increment the bit counter.
  - After the W-th bit, enter DONE.
- DONE:
  - Outputs: done=1, count = final hit total, done_id = winner.
  - ptr = (winner+1) mod 4.
  - Next edge: go to IDLE and clear gnt.
- Detector state y is cleared at every job start, so no hit is counted across a word boundary.
- Requests:
  - req changes during SHIFT or DONE are ignored. The job always completes.
  - din is sampled only at the grant edge.
  - A requester still asserting req in IDLE after its own done is treated as a new request at lowest priority.
- Arithmetic: the hit counter never exceeds W-1 and cannot overflow in $clog2(W)+1 bits.
- Reset values: state IDLE, gnt 0, busy 0, sbit 0, z 0, done 0, done_id 0, count 0, ptr 0, y 0, shreg 0.

## Timing
- Cycle numbering: the edge that samples req in IDLE ends cycle 0.
- gnt and busy are high from cycle 1 through cycle W+1.
- SHIFT occupies cycles 1..W. Cycle k presents din bit W-k.
- done is high in cycle W+1 only.
- Cycle W+2 is IDLE. The earliest next grant edge ends cycle W+2, so the job period is W+2 cycles.
- z is valid combinationally within each SHIFT cycle. Hits are accumulated at the end of that cycle.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - The job is dropped with no done pulse.
  - Arbitration restarts with requester 0 at highest priority.

## Test plan
- After reset, req=4'b0001, word0=8'b0110_1110:
  - sbit sequence is 0,1,1,0,1,1,1,0.
  - z is high in cycles 3, 6 and 7.
  - done in cycle 9 with count=3, done_id=0.
- Single-requester edge words:
  - 8'hFF → count=7.
  - 8'h00 → count=0.
  - 8'hAA → count=0.
- Hold req=4'b1111 with distinct words:
  - Grants go 0,1,2,3,0 in that order.
  - Each done_id matches its grant, and each count matches that requester's word.
- Cross-word isolation:
  - Requester 0 sends 8'h01; requester 1 then sends 8'h80.
  - Both counts are 0; detector state does not carry over.
- Mid-job changes:
  - Drop req and change din mid-SHIFT.
  - The job completes with a count based on the word sampled at grant.
- Reset mid-job:
  - Assert Resetn=0 in cycle 4 of a job.
  - gnt, busy, z and done drop to 0 asynchronously, with no done pulse.
  - After release with req=4'b0110, the first grant goes to requester 1.

Source files
------------

// File: rtl/serial_match_scheduler_if.sv
// serial_match_scheduler_if
// Bundles the requester-side request/data signals and the scheduler's
// grant, serial-detector and completion outputs.
//   req     : per-requester request, bit i = requester i
//   din     : requester words, din[i*W +: W] = requester i
//   gnt     : one-hot registered grant
//   busy    : job in progress (SHIFT or DONE)
//   sbit, z : bit presented to the shared detector and its Mealy output
//   done    : one-cycle completion pulse
//   done_id : requester whose job completed (held)
//   count   : detector hits for the completed word (held)
// Modports: master = requester front-ends, slave = scheduler.
interface serial_match_scheduler_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W) + 1;

  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic           busy;
  logic           sbit;
  logic           z;
  logic           done;
  logic [1:0]     done_id;
  logic [CW-1:0]  count;

  modport master (
    output req, din,
    input  gnt, busy, sbit, z, done, done_id, count
  );

  modport slave (
    input  req, din,
    output gnt, busy, sbit, z, done, done_id, count
  );
endinterface

// File: rtl/serial_match_scheduler.sv
// serial_match_scheduler
// Shares one bit-serial "two consecutive 1s" Mealy detector among four
// requesters. A round-robin arbiter picks a requester, its word is shifted
// MSB-first through the detector, hits are counted and reported with a
// one-cycle done pulse tagged with the requester ID.
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : serial_match_scheduler_if slave modport (req/din in,
//            gnt/busy/sbit/z/done/done_id/count out)
//
// state | meaning
// IDLE  | waiting for any request; arbitrate and load on the grant edge
// SHIFT | presenting shreg MSB to the detector, one bit per cycle
// DONE  | done pulse; count/done_id valid; advance round-robin pointer
module serial_match_scheduler #(
  parameter int W = 8
) (
  input logic                     Clock,
  input logic                     Resetn,
  serial_match_scheduler_if.slave bus
);
  localparam int CW = $clog2(W) + 1;
  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    winner;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bitcnt;
  logic [CW-1:0] hitcnt;
  logic          y;
  logic [3:0]    gnt_q;
  logic [1:0]    done_id_q;
  logic [CW-1:0] count_q;

  logic [1:0]    pick;
  logic          found;
  logic [1:0]    idx;
  logic          sbit_i;
  logic          z_i;
  logic          last_bit;

  // Round-robin search starting at ptr; first requester found wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sbit_i   = (state == SHIFT) & shreg[W-1];
  assign z_i      = sbit_i & y;
  assign last_bit = (bitcnt == BW'(W - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ptr       <= '0;
      winner    <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
      hitcnt    <= '0;
      y         <= 1'b0;
      gnt_q     <= '0;
      done_id_q <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            shreg  <= bus.din[pick*W +: W];
            gnt_q  <= 4'b0001 << pick;
            winner <= pick;
            bitcnt <= '0;
            hitcnt <= '0;
            y      <= 1'b0;
          end
        end
        SHIFT: begin
          shreg  <= {shreg[W-2:0], 1'b0};
          y      <= sbit_i;
          hitcnt <= hitcnt + CW'(z_i);
          bitcnt <= bitcnt + BW'(1);
          // Capture the total including the final bit's hit so count is
          // already valid during the DONE cycle.
          if (last_bit) begin
            count_q   <= hitcnt + CW'(z_i);
            done_id_q <= winner;
          end
        end
        DONE: begin
          gnt_q <= '0;
          ptr   <= winner + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.sbit    = sbit_i;
  assign bus.z       = z_i;
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id_q;
  assign bus.count   = count_q;
endmodule
